// File: rtl/clk_seq_pkg.sv
// Shared definitions for the ADC clock-source sequencer.
//   state_e         : sequencer state, 3-bit encoding reported on state_o
//   PHASE_W         : width of the phase-shift value
//   SYNC_DEPTH      : flops in the dcm_locked_i synchroniser
//   PHASE_DONE_MASK : cycles of PHASE_WAIT during which phase_done_i is ignored
package clk_seq_pkg;

    typedef enum logic [2:0] {
        INT_RUN    = 3'd0,
        DCM_RST    = 3'd1,
        WAIT_LOCK  = 3'd2,
        PHASE_LOAD = 3'd3,
        PHASE_WAIT = 3'd4,
        EXT_RUN    = 3'd5,
        FAULT      = 3'd6
    } state_e;

    localparam int unsigned PHASE_W         = 9;
    localparam int unsigned SYNC_DEPTH      = 2;
    localparam int unsigned PHASE_DONE_MASK = 2;

endpackage

// File: rtl/lock_qualifier.sv
// Synchronises the asynchronous DCM lock and qualifies it as stable.
//   clk_i        : control clock
//   reset_n_i    : synchronous active-low reset
//   dcm_locked_i : raw DCM lock, asynchronous to clk_i
//   clear_i      : holds the stable counter at zero (outside WAIT_LOCK)
//   lock_s_o     : synchronised lock
//   lock_ok_o    : high in the cycle that completes LOCK_STABLE consecutive
//                  synchronised-lock cycles while not cleared
module lock_qualifier
    import clk_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic dcm_locked_i,
    input  logic clear_i,
    output logic lock_s_o,
    output logic lock_ok_o
);

    localparam int unsigned STABLE_W = $clog2(LOCK_STABLE + 1);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic [STABLE_W-1:0]   stable_q, stable_d;

    assign lock_s_o = sync_q[SYNC_DEPTH-1];

    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], dcm_locked_i};

        stable_d = stable_q;
        if (clear_i || !lock_s_o) begin
            stable_d = '0;
        end else if (stable_q != STABLE_W'(LOCK_STABLE)) begin
            stable_d = stable_q + 1'b1;
        end

        // stable_q counts earlier lock cycles, so the current lock cycle
        // completing the run is recognised without an extra cycle of delay.
        lock_ok_o = lock_s_o && !clear_i &&
                    (stable_q >= STABLE_W'(LOCK_STABLE - 1));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sync_q   <= '0;
            stable_q <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/clock_source_sequencer.sv
// Sequences the ADC clock mux between the internal clock and the external
// DCM-derived clock: DCM reset, lock qualification, phase reload, mux select,
// bounded retry on failure and lock-loss recovery.
//   clk_i, reset_n_i     : control clock, synchronous active-low reset
//   use_ext_clk_req_i    : register request, 1 = external clock
//   phase_value_i        : requested phase value
//   dcm_locked_i         : DCM lock (asynchronous)
//   phase_done_i         : phase-shift interface done (level)
//   use_ext_clk_o        : clock-mux select
//   dcm_reset_o          : DCM reset
//   phase_requested_o    : value presented to the phase-shift interface
//   phase_load_o         : one-cycle load strobe
//   ready_o / fault_o    : selected clock valid / external clock failed
//   retry_count_o        : attempts consumed in the current sequence
//   relock_count_o       : lock-loss events in EXT_RUN, saturating
//   state_o              : current state encoding
module clock_source_sequencer
    import clk_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 1048576,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               use_ext_clk_req_i,
    input  logic [PHASE_W-1:0] phase_value_i,
    input  logic               dcm_locked_i,
    input  logic               phase_done_i,
    output logic               use_ext_clk_o,
    output logic               dcm_reset_o,
    output logic [PHASE_W-1:0] phase_requested_o,
    output logic               phase_load_o,
    output logic               ready_o,
    output logic               fault_o,
    output logic [1:0]         retry_count_o,
    output logic [7:0]         relock_count_o,
    output logic [2:0]         state_o
);

    localparam int unsigned TIMER_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned RST_W   = $clog2(RST_CYCLES + 1);

    state_e               state_q, state_d;
    logic                 use_ext_q, use_ext_d;
    logic                 dcm_reset_q, dcm_reset_d;
    logic                 phase_load_q, phase_load_d;
    logic                 ready_q, ready_d;
    logic                 fault_q, fault_d;
    logic [1:0]           retry_q, retry_d;
    logic [7:0]           relock_q, relock_d;
    logic [PHASE_W-1:0]   phase_req_q, phase_req_d;
    logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
    logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic                 timeout;
    logic                 fail;
    logic                 lock_s;
    logic                 lock_ok;
    logic                 stable_clear;

    assign stable_clear = (state_q != WAIT_LOCK);

    lock_qualifier #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_qualifier (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .dcm_locked_i(dcm_locked_i),
        .clear_i     (stable_clear),
        .lock_s_o    (lock_s),
        .lock_ok_o   (lock_ok)
    );

    always_comb begin
        state_d      = state_q;
        use_ext_d    = use_ext_q;
        dcm_reset_d  = dcm_reset_q;
        phase_load_d = 1'b0;
        ready_d      = ready_q;
        fault_d      = fault_q;
        retry_d      = retry_q;
        relock_d     = relock_q;
        phase_req_d  = phase_req_q;
        timer_d      = timer_q;
        rst_cnt_d    = rst_cnt_q;
        fail         = 1'b0;

        // Terminal count is checked on the incremented value so the state
        // lasts exactly LOCK_TIMEOUT cycles and the timer never wraps.
        timer_inc = timer_q + 1'b1;
        timeout   = (timer_inc == TIMER_W'(LOCK_TIMEOUT));

        if (state_q != INT_RUN && !use_ext_clk_req_i) begin
            state_d = INT_RUN;
        end else begin
            case (state_q)
                INT_RUN: begin
                    if (use_ext_clk_req_i) begin
                        retry_d = '0;
                        state_d = DCM_RST;
                    end
                end
                DCM_RST: begin
                    if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_ok) begin
                        state_d = PHASE_LOAD;
                    end else if (timeout) begin
                        fail = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                PHASE_LOAD: begin
                    state_d = PHASE_WAIT;
                end
                PHASE_WAIT: begin
                    if (!lock_s) begin
                        fail = 1'b1;
                    end else if (phase_done_i &&
                                 timer_q >= TIMER_W'(PHASE_DONE_MASK)) begin
                        state_d = EXT_RUN;
                    end else if (timeout) begin
                        fail = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                EXT_RUN: begin
                    if (!lock_s) begin
                        if (relock_q != '1) begin
                            relock_d = relock_q + 1'b1;
                        end
                        retry_d = '0;
                        state_d = DCM_RST;
                    end else if (phase_value_i != phase_req_q) begin
                        state_d = PHASE_LOAD;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = INT_RUN;
                end
            endcase

            if (fail) begin
                if (retry_q < 2'(MAX_RETRIES)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = DCM_RST;
                end else begin
                    state_d = FAULT;
                end
            end
        end

        if (state_d != state_q) begin
            timer_d   = '0;
            rst_cnt_d = '0;
        end

        if (state_d == PHASE_LOAD) begin
            phase_req_d  = phase_value_i;
            phase_load_d = 1'b1;
        end

        // Outputs are decoded from the next state so they register together
        // with state_q.
        case (state_d)
            INT_RUN: begin
                use_ext_d = 1'b0; dcm_reset_d = 1'b1; ready_d = 1'b1; fault_d = 1'b0;
            end
            DCM_RST: begin
                use_ext_d = 1'b0; dcm_reset_d = 1'b1; ready_d = 1'b0; fault_d = 1'b0;
            end
            WAIT_LOCK: begin
                use_ext_d = 1'b0; dcm_reset_d = 1'b0; ready_d = 1'b0; fault_d = 1'b0;
            end
            PHASE_LOAD, PHASE_WAIT: begin
                // Holding the select keeps the external clock on during a
                // phase change from EXT_RUN, and off during first bring-up.
                use_ext_d = use_ext_q; dcm_reset_d = 1'b0; ready_d = 1'b0; fault_d = 1'b0;
            end
            EXT_RUN: begin
                use_ext_d = 1'b1; dcm_reset_d = 1'b0; ready_d = 1'b1; fault_d = 1'b0;
            end
            FAULT: begin
                use_ext_d = 1'b0; dcm_reset_d = 1'b1; ready_d = 1'b0; fault_d = 1'b1;
            end
            default: begin
                use_ext_d = 1'b0; dcm_reset_d = 1'b1; ready_d = 1'b0; fault_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= INT_RUN;
            use_ext_q    <= 1'b0;
            dcm_reset_q  <= 1'b1;
            phase_load_q <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            retry_q      <= '0;
            relock_q     <= '0;
            phase_req_q  <= '0;
            timer_q      <= '0;
            rst_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            use_ext_q    <= use_ext_d;
            dcm_reset_q  <= dcm_reset_d;
            phase_load_q <= phase_load_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            retry_q      <= retry_d;
            relock_q     <= relock_d;
            phase_req_q  <= phase_req_d;
            timer_q      <= timer_d;
            rst_cnt_q    <= rst_cnt_d;
        end
    end

    assign use_ext_clk_o     = use_ext_q;
    assign dcm_reset_o       = dcm_reset_q;
    assign phase_load_o      = phase_load_q;
    assign ready_o           = ready_q;
    assign fault_o           = fault_q;
    assign retry_count_o     = retry_q;
    assign relock_count_o    = relock_q;
    assign phase_requested_o = phase_req_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_clock_source_sequencer.sv
// Bench for clock_source_sequencer: directed scenarios with literal
// expectations plus randomized stimulus against a cycle-level reference model.
module tb_clock_source_sequencer;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 16;
    localparam int LOCK_TIMEOUT = 100;
    localparam int MAX_RETRIES  = 3;

    logic       clk = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       use_ext_clk_req_i = 1'b0;
    logic [8:0] phase_value_i = '0;
    logic       dcm_locked_i = 1'b0;
    logic       phase_done_i = 1'b0;
    logic       use_ext_clk_o, dcm_reset_o, phase_load_o, ready_o, fault_o;
    logic [8:0] phase_requested_o;
    logic [1:0] retry_count_o;
    logic [7:0] relock_count_o;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    clock_source_sequencer #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .MAX_RETRIES (MAX_RETRIES)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n_i),
        .use_ext_clk_req_i(use_ext_clk_req_i),
        .phase_value_i    (phase_value_i),
        .dcm_locked_i     (dcm_locked_i),
        .phase_done_i     (phase_done_i),
        .use_ext_clk_o    (use_ext_clk_o),
        .dcm_reset_o      (dcm_reset_o),
        .phase_requested_o(phase_requested_o),
        .phase_load_o     (phase_load_o),
        .ready_o          (ready_o),
        .fault_o          (fault_o),
        .retry_count_o    (retry_count_o),
        .relock_count_o   (relock_count_o),
        .state_o          (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Modes: 0 internal, 1 dcm reset, 2 wait lock, 3 load, 4 phase wait,
    // 5 external, 6 fault. elapsed = cycles spent in the current mode,
    // run = consecutive synchronised-lock cycles seen while waiting for lock.
    int m_mode, m_elapsed, m_run, m_retry, m_relock, m_phase;
    int m_use_ext, m_dcm_reset, m_load, m_ready, m_fault;
    int hist0, hist1;
    bit armed = 0;

    always @(posedge clk) begin
        int nxt, ls;
        bit f;
        if (!reset_n_i) begin
            m_mode = 0; m_elapsed = 0; m_run = 0; m_retry = 0; m_relock = 0; m_phase = 0;
            m_use_ext = 0; m_dcm_reset = 1; m_load = 0; m_ready = 0; m_fault = 0;
            hist0 = 0; hist1 = 0;
            armed = 1;
        end else begin
            ls = hist1;
            nxt = m_mode;
            f = 0;
            if (m_mode != 0 && !use_ext_clk_req_i) nxt = 0;
            else begin
                case (m_mode)
                    0: if (use_ext_clk_req_i) begin m_retry = 0; nxt = 1; end
                    1: begin m_elapsed++; if (m_elapsed == RST_CYCLES) nxt = 2; end
                    2: begin
                        m_run = ls ? m_run + 1 : 0;
                        m_elapsed++;
                        if (m_run == LOCK_STABLE) nxt = 3;
                        else if (m_elapsed == LOCK_TIMEOUT) f = 1;
                    end
                    3: nxt = 4;
                    4: begin
                        if (!ls) f = 1;
                        else if (phase_done_i && m_elapsed >= 2) nxt = 5;
                        else begin
                            m_elapsed++;
                            if (m_elapsed == LOCK_TIMEOUT) f = 1;
                        end
                    end
                    5: begin
                        if (!ls) begin
                            if (m_relock < 255) m_relock++;
                            m_retry = 0;
                            nxt = 1;
                        end else if (int'(phase_value_i) != m_phase) nxt = 3;
                    end
                    default: ;
                endcase
                if (f) begin
                    if (m_retry < MAX_RETRIES) begin m_retry++; nxt = 1; end
                    else nxt = 6;
                end
            end
            if (nxt != m_mode) begin m_elapsed = 0; m_run = 0; end
            m_load = 0;
            if (nxt == 3) begin m_phase = int'(phase_value_i); m_load = 1; end
            if (nxt == 5) m_use_ext = 1;
            else if (nxt != 3 && nxt != 4) m_use_ext = 0;
            m_ready     = (nxt == 0 || nxt == 5) ? 1 : 0;
            m_dcm_reset = (nxt == 0 || nxt == 1 || nxt == 6) ? 1 : 0;
            m_fault     = (nxt == 6) ? 1 : 0;
            m_mode = nxt;
            hist1 = hist0;
            hist0 = int'(dcm_locked_i);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("state",      state_o,           m_mode);
            chk("use_ext",    use_ext_clk_o,     m_use_ext);
            chk("dcm_reset",  dcm_reset_o,       m_dcm_reset);
            chk("phase_load", phase_load_o,      m_load);
            chk("ready",      ready_o,           m_ready);
            chk("fault",      fault_o,           m_fault);
            chk("retry",      retry_count_o,     m_retry);
            chk("relock",     relock_count_o,    m_relock);
            chk("phase_req",  phase_requested_o, m_phase);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, cnt, loads, val, k, ext_low, ready_bad, prev;
        bit seen;

        // Reset and idle
        repeat (3) tick();
        chk("rst_state", state_o, 0);
        chk("rst_dcm_reset", dcm_reset_o, 1);
        chk("rst_use_ext", use_ext_clk_o, 0);
        chk("rst_ready", ready_o, 0);
        reset_n_i = 1'b1;
        tick();
        chk("ready_after_release", ready_o, 1);
        chk("idle_state", state_o, 0);

        // Nominal bring-up with phase 37
        use_ext_clk_req_i = 1'b1;
        phase_value_i = 9'd37;
        n = 0; cnt = 0;
        while (dcm_reset_o !== 1'b0 && n < 40) begin
            tick(); n++;
            if (state_o == 3'd1 && dcm_reset_o == 1'b1) cnt++;
        end
        chk("dcm_reset_len", cnt, 4);
        chk("wait_lock_state", state_o, 2);
        repeat (9) tick();
        dcm_locked_i = 1'b1;
        n = 0;
        while (phase_load_o !== 1'b1 && n < 100) begin tick(); n++; end
        chk("load_seen", phase_load_o, 1);
        chk("load_value", phase_requested_o, 37);
        loads = 1;
        repeat (4) begin tick(); if (phase_load_o) loads++; end
        phase_done_i = 1'b1;
        n = 0;
        while (state_o !== 3'd5 && n < 20) begin tick(); n++; if (phase_load_o) loads++; end
        chk("load_pulses", loads, 1);
        chk("ext_state", state_o, 5);
        chk("ext_use_ext", use_ext_clk_o, 1);
        chk("ext_ready", ready_o, 1);
        chk("model_ext_mode", m_mode, 5);

        // One-cycle lock drop in EXT_RUN
        dcm_locked_i = 1'b0;
        tick();
        dcm_locked_i = 1'b1;
        n = 1;
        while (use_ext_clk_o !== 1'b0 && n < 10) begin tick(); n++; end
        chk("drop_latency_le3", (n <= 3), 1);
        chk("drop_use_ext", use_ext_clk_o, 0);
        chk("relock_one", relock_count_o, 1);
        chk("drop_state", state_o, 1);
        n = 0;
        while (state_o !== 3'd5 && n < 200) begin tick(); n++; end
        chk("relock_ext_state", state_o, 5);
        chk("relock_use_ext", use_ext_clk_o, 1);
        chk("relock_retry", retry_count_o, 0);

        // Phase change 37 -> 200 while running external
        phase_done_i = 1'b0;
        tick();
        phase_value_i = 9'd200;
        n = 0; loads = 0; val = 0; k = 0; ext_low = 0; ready_bad = 0; seen = 0;
        while (n < 60) begin
            tick(); n++;
            if (phase_load_o) begin loads++; val = int'(phase_requested_o); seen = 1; end
            if (state_o == 3'd5 && seen) break;
            if (use_ext_clk_o !== 1'b1) ext_low++;
            if (ready_o !== 1'b0) ready_bad++;
            if (seen) begin k++; if (k == 3) phase_done_i = 1'b1; end
        end
        chk("chg_load_pulses", loads, 1);
        chk("chg_load_value", val, 200);
        chk("chg_use_ext_low", ext_low, 0);
        chk("chg_ready_early", ready_bad, 0);
        chk("chg_ready_end", ready_o, 1);
        chk("chg_state", state_o, 5);

        // Lock never arrives: bounded retries then FAULT
        use_ext_clk_req_i = 1'b0;
        phase_done_i = 1'b0;
        dcm_locked_i = 1'b0;
        repeat (3) tick();
        use_ext_clk_req_i = 1'b1;
        prev = int'(state_o); cnt = 0; n = 0;
        while (state_o !== 3'd6 && n < 600) begin
            tick(); n++;
            if (state_o == 3'd1 && prev != 1) cnt++;
            prev = int'(state_o);
        end
        chk("attempts", cnt, 4);
        chk("fault_retry", retry_count_o, 3);
        chk("fault_flag", fault_o, 1);
        chk("fault_dcm_reset", dcm_reset_o, 1);
        repeat (5) tick();
        chk("fault_sticky", state_o, 6);
        use_ext_clk_req_i = 1'b0;
        tick();
        chk("fault_exit_state", state_o, 0);
        chk("fault_exit_flag", fault_o, 0);
        chk("fault_exit_ready", ready_o, 1);

        // Request dropped during WAIT_LOCK
        use_ext_clk_req_i = 1'b1;
        n = 0;
        while (state_o !== 3'd2 && n < 20) begin tick(); n++; end
        repeat (3) tick();
        use_ext_clk_req_i = 1'b0;
        tick();
        chk("abort_state", state_o, 0);
        chk("abort_dcm_reset", dcm_reset_o, 1);
        chk("abort_load", phase_load_o, 0);

        // Reset asserted during PHASE_WAIT
        dcm_locked_i = 1'b1;
        repeat (3) tick();
        use_ext_clk_req_i = 1'b1;
        n = 0;
        while (state_o !== 3'd4 && n < 100) begin tick(); n++; end
        chk("pw_reached", state_o, 4);
        tick();
        reset_n_i = 1'b0;
        tick();
        chk("pw_rst_state", state_o, 0);
        chk("pw_rst_dcm_reset", dcm_reset_o, 1);
        chk("pw_rst_load", phase_load_o, 0);
        reset_n_i = 1'b1;
        loads = 0;
        repeat (5) begin tick(); if (phase_load_o) loads++; end
        chk("pw_rst_no_load", loads, 0);

        // Randomized profiles: good lock, dead lock, flaky lock
        for (int seg = 0; seg < 25; seg++) begin
            int prof;
            prof = $urandom_range(0, 2);
            for (int c = 0; c < 600; c++) begin
                case (prof)
                    0: dcm_locked_i = ($urandom_range(0, 299) != 0);
                    1: dcm_locked_i = 1'b0;
                    default: dcm_locked_i = ($urandom_range(0, 3) != 0);
                endcase
                phase_done_i = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 149) == 0) phase_value_i = 9'($urandom);
                use_ext_clk_req_i = ($urandom_range(0, 599) != 0);
                reset_n_i = ($urandom_range(0, 2999) != 0);
                tick();
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
